// File: rtl/receiver_if.sv
// Serial receive bus: pad-side line in, host-side byte, strobe and status out.
interface receiver_if;
    logic       RX_DATA_in;
    logic [7:0] RX_DATA;
    logic       RX_valid;
    logic       RX_busy;
    logic       RX_parity_err;
    logic       RX_frame_err;

    modport master (
        input  RX_DATA_in,
        output RX_DATA,
        output RX_valid,
        output RX_busy,
        output RX_parity_err,
        output RX_frame_err
    );

    modport slave (
        output RX_DATA_in,
        input  RX_DATA,
        input  RX_valid,
        input  RX_busy,
        input  RX_parity_err,
        input  RX_frame_err
    );
endinterface

// File: rtl/receiver.sv
// UART receive half: start, 8 data bits LSB first, even parity, stop; mid-bit sampling
// with a free-running bit timer and a one-cycle valid strobe carrying per-frame error flags.
module receiver #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input logic        clk,
    input logic        rst,
    receiver_if.master rx_io
);

    localparam int unsigned Half   = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] TimerHalf = TimerW'(Half);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q;
    logic              sync1_q;
    logic              sync2_q;
    logic [TimerW-1:0] timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic              armed_q;
    logic [7:0]        data_q;
    logic              valid_q;
    logic              busy_q;
    logic              perr_q;
    logic              ferr_q;

    logic              rx_s;
    logic              sample;
    logic [TimerW-1:0] timer_inc;

    assign rx_s      = sync2_q;
    assign sample    = (timer_q == TimerHalf);
    assign timer_inc = (timer_q == TimerLast) ? '0 : timer_q + TimerW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q <= rx_io.RX_DATA_in;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end
                    // Detection cycle counts as timer 0; the timer carries on from there.
                    if (armed_q && !rx_s) begin
                        timer_q   <= timer_inc;
                        busy_q    <= 1'b1;
                        bit_idx_q <= '0;
                        if (Half == 0) begin
                            state_q <= StData;
                        end else begin
                            state_q <= StStart;
                        end
                    end
                end

                StStart: begin
                    timer_q <= timer_inc;
                    if (sample) begin
                        if (rx_s) begin
                            state_q <= StIdle;
                            timer_q <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end
                    end
                end

                StData: begin
                    timer_q <= timer_inc;
                    if (sample) begin
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StParity;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                StParity: begin
                    timer_q <= timer_inc;
                    if (sample) begin
                        parity_q <= rx_s;
                        state_q  <= StStop;
                    end
                end

                StStop: begin
                    timer_q <= timer_inc;
                    if (sample) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                        perr_q  <= (parity_q != ^shift_q);
                        ferr_q  <= ~rx_s;
                        // A bad stop disarms so a held-low break cannot retrigger.
                        armed_q <= rx_s;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_io.RX_DATA       = data_q;
    assign rx_io.RX_valid      = valid_q;
    assign rx_io.RX_busy       = busy_q;
    assign rx_io.RX_parity_err = perr_q;
    assign rx_io.RX_frame_err  = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver at one and sixteen clocks per bit, with a strobe scoreboard.
module tb_receiver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    receiver_if if1 ();
    receiver_if if16 ();

    receiver #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .rx_io (if1)
    );

    receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .rx_io (if16)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         at;
    } exp_t;

    exp_t q1[$];
    exp_t q16[$];
    exp_t e1;
    exp_t e16;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued frame, at its predicted cycle.
    always @(negedge clk) begin
        if (if1.RX_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected strobe", 32'(if1.RX_valid), 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1 data", 32'(if1.RX_DATA), 32'(e1.data));
                check("dut1 parity_err", 32'(if1.RX_parity_err), 32'(e1.perr));
                check("dut1 frame_err", 32'(if1.RX_frame_err), 32'(e1.ferr));
                check("dut1 strobe cycle", 32'(cyc), 32'(e1.at));
                check("dut1 busy on strobe", 32'(if1.RX_busy), 32'd0);
            end
        end
        if (if16.RX_valid === 1'b1) begin
            if (q16.size() == 0) begin
                check("dut16 unexpected strobe", 32'(if16.RX_valid), 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("dut16 data", 32'(if16.RX_DATA), 32'(e16.data));
                check("dut16 parity_err", 32'(if16.RX_parity_err), 32'(e16.perr));
                check("dut16 frame_err", 32'(if16.RX_frame_err), 32'(e16.ferr));
                check("dut16 strobe cycle", 32'(cyc), 32'(e16.at));
                check("dut16 busy on strobe", 32'(if16.RX_busy), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 1) if1.RX_DATA_in = v;
        else if16.RX_DATA_in = v;
    endtask

    // Drives one frame starting now; predicts the strobe cycle from the pin-side start.
    task automatic send(input int which, input logic [7:0] d, input logic par, input logic stop);
        int          c;
        int          half;
        logic [10:0] bits;
        exp_t        e;
        c      = (which == 1) ? 1 : 16;
        half   = (c - 1) / 2;
        bits   = {stop, par, d, 1'b0};
        e.data = d;
        e.perr = (par != ^d);
        e.ferr = ~stop;
        e.at   = cyc + 2 + half + 10 * c + 1;
        if (which == 1) q1.push_back(e);
        else q16.push_back(e);
        for (int k = 0; k < 11; k++) begin
            set_line(which, bits[k]);
            step(c);
        end
    endtask

    task automatic check_reset_outputs(input string who, input int which);
        if (which == 1) begin
            check({who, " data"}, 32'(if1.RX_DATA), 32'h00);
            check({who, " valid"}, 32'(if1.RX_valid), 32'd0);
            check({who, " busy"}, 32'(if1.RX_busy), 32'd0);
            check({who, " parity_err"}, 32'(if1.RX_parity_err), 32'd0);
            check({who, " frame_err"}, 32'(if1.RX_frame_err), 32'd0);
        end else begin
            check({who, " data"}, 32'(if16.RX_DATA), 32'h00);
            check({who, " valid"}, 32'(if16.RX_valid), 32'd0);
            check({who, " busy"}, 32'(if16.RX_busy), 32'd0);
            check({who, " parity_err"}, 32'(if16.RX_parity_err), 32'd0);
            check({who, " frame_err"}, 32'(if16.RX_frame_err), 32'd0);
        end
    endtask

    logic [7:0] partial;

    initial begin
        rst = 1'b1;
        set_line(1, 1'b1);
        set_line(16, 1'b1);
        step(2);
        rst = 1'b0;
        check_reset_outputs("reset dut1", 1);
        check_reset_outputs("reset dut16", 16);
        step(4);

        // Good frame, one clock per bit.
        send(1, 8'hA5, 1'b0, 1'b1);
        step(5);
        check("A5 delivered", 32'(q1.size()), 32'd0);
        step(10);
        check("A5 held", 32'(if1.RX_DATA), 32'hA5);

        // Bad parity, then the same byte with correct parity back-to-back.
        send(1, 8'h07, 1'b0, 1'b1);
        send(1, 8'h07, 1'b1, 1'b1);
        step(5);
        check("07 pair delivered", 32'(q1.size()), 32'd0);

        // Missing stop bit followed by a break: exactly one strobe, no retrigger.
        send(1, 8'h3C, 1'b0, 1'b0);
        step(30);
        check("break busy", 32'(if1.RX_busy), 32'd0);
        check("break frame_err held", 32'(if1.RX_frame_err), 32'd1);
        set_line(1, 1'b1);
        step(5);
        send(1, 8'h55, 1'b0, 1'b1);
        step(5);
        check("55 delivered", 32'(q1.size()), 32'd0);

        // Short low glitch at sixteen clocks per bit is rejected as a false start.
        set_line(16, 1'b0);
        step(3);
        check("glitch busy rises", 32'(if16.RX_busy), 32'd1);
        step(2);
        set_line(16, 1'b1);
        step(40);
        check("glitch busy falls", 32'(if16.RX_busy), 32'd0);
        check("glitch no strobe data", 32'(if16.RX_DATA), 32'h00);

        send(16, 8'h81, 1'b0, 1'b1);
        send(16, 8'h7E, 1'b0, 1'b1);
        step(10);
        check("81/7E delivered", 32'(q16.size()), 32'd0);

        // Reset lands while data bit 4 of a frame is on the pin.
        partial = 8'hC3;
        set_line(1, 1'b0);
        step(1);
        for (int k = 0; k < 4; k++) begin
            set_line(1, partial[k]);
            step(1);
        end
        set_line(1, partial[4]);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        set_line(1, 1'b1);
        step(20);
        check_reset_outputs("midframe dut1", 1);
        check_reset_outputs("midframe dut16", 16);
        send(1, 8'hC3, 1'b0, 1'b1);
        step(5);

        check("dut1 queue drained", 32'(q1.size()), 32'd0);
        check("dut16 queue drained", 32'(q16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
